// File: rtl/sbus_arbiter.sv
// Arbitrates N_CH sbus masters onto a single sbus slave port, one transfer at a time.
// Define SBUS_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module sbus_arbiter #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_CH-1:0]          m_en,
    input  logic [N_CH-1:0]          m_we,
    input  logic [2*N_CH-1:0]        m_size,
    input  logic [ADDR_W*N_CH-1:0]   m_addr,
    input  logic [DATA_W*N_CH-1:0]   m_data_w,
    output logic [DATA_W*N_CH-1:0]   m_data_r,
    output logic [N_CH-1:0]          m_stall,
    output logic                     s_en,
    output logic                     s_we,
    output logic [1:0]               s_size,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_data_w,
    input  logic [DATA_W-1:0]        s_data_r,
    input  logic                     s_stall,
    output logic [N_CH-1:0]          gnt
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic StIdle = 1'b0;
    localparam logic StBusy = 1'b1;

    logic             state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx;
    logic             found;

`ifdef SBUS_ARB_FIXED_PRIO_EN
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = IDX_W'(k);
            if (!found && m_en[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_q, rr_d;

    // Scan channels starting at rr, wrapping; first requester wins.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = IDX_W'((32'(rr_q) + k) % N_CH);
            if (!found && m_en[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Pointer only advances on a real completion, not on withdrawal.
    always_comb begin
        rr_d = rr_q;
        if (state_q == StBusy && m_en[g_q] && !s_stall) begin
            rr_d = (g_q == IDX_W'(N_CH - 1)) ? '0 : g_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            StIdle: begin
                if (|m_en) begin
                    g_d     = win;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!m_en[g_q] || !s_stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    always_comb begin
        s_en     = 1'b0;
        s_we     = 1'b0;
        s_size   = '0;
        s_addr   = '0;
        s_data_w = '0;
        gnt      = '0;
        m_stall  = m_en;
        if (state_q == StBusy) begin
            s_en         = m_en[g_q];
            s_we         = m_we[g_q];
            s_size       = m_size[2*g_q +: 2];
            s_addr       = m_addr[ADDR_W*g_q +: ADDR_W];
            s_data_w     = m_data_w[DATA_W*g_q +: DATA_W];
            gnt[g_q]     = 1'b1;
            m_stall[g_q] = s_stall;
        end
    end

    assign m_data_r = {N_CH{s_data_r}};

endmodule

// File: tb/tb_sbus_arbiter.sv
// Self-checking bench for sbus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_sbus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    m_en, m_we;
    logic [2*N-1:0]  m_size;
    logic [AW*N-1:0] m_addr;
    logic [DW*N-1:0] m_data_w, m_data_r;
    logic [N-1:0]    m_stall, gnt;
    logic            s_en, s_we, s_stall;
    logic [1:0]      s_size;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_data_w, s_data_r;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus (if anyone) and the next round-robin start.
    bit md_busy;
    int md_owner;
    int md_rr;

    logic [3:0] exp_alt [4];

    sbus_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_size   (m_size),
        .m_addr   (m_addr),
        .m_data_w (m_data_w),
        .m_data_r (m_data_r),
        .m_stall  (m_stall),
        .s_en     (s_en),
        .s_we     (s_we),
        .s_size   (s_size),
        .s_addr   (s_addr),
        .s_data_w (s_data_w),
        .s_data_r (s_data_r),
        .s_stall  (s_stall),
        .gnt      (gnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] en, int rr);
`ifdef SBUS_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (en[k]) return k;
`else
        for (int k = 0; k < N; k++) if (en[(rr + k) % N]) return (rr + k) % N;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        md_busy  = 1'b0;
        md_owner = 0;
        md_rr    = 0;
    endtask

    task automatic model_edge();
        if (!md_busy) begin
            if (m_en != '0) begin
                md_owner = pick(m_en, md_rr);
                md_busy  = 1'b1;
            end
        end else if (!m_en[md_owner]) begin
            md_busy = 1'b0;
        end else if (!s_stall) begin
            md_busy = 1'b0;
            md_rr   = (md_owner + 1) % N;
        end
    endtask

    task automatic check_outputs(string tag);
        logic [N-1:0] es, eg;
        es = m_en;
        eg = '0;
        if (md_busy) begin
            es[md_owner] = s_stall;
            eg[md_owner] = 1'b1;
        end
        check_eq({tag, "/gnt"}, 64'(gnt), 64'(eg));
        check_eq({tag, "/m_stall"}, 64'(m_stall), 64'(es));
        check_eq({tag, "/s_en"}, 64'(s_en), md_busy ? 64'(m_en[md_owner]) : 64'd0);
        check_eq({tag, "/s_we"}, 64'(s_we), md_busy ? 64'(m_we[md_owner]) : 64'd0);
        check_eq({tag, "/s_size"}, 64'(s_size),
                 md_busy ? 64'(m_size[2*md_owner +: 2]) : 64'd0);
        check_eq({tag, "/s_addr"}, 64'(s_addr),
                 md_busy ? 64'(m_addr[AW*md_owner +: AW]) : 64'd0);
        check_eq({tag, "/s_data_w"}, s_data_w,
                 md_busy ? m_data_w[DW*md_owner +: DW] : 64'd0);
        for (int k = 0; k < N; k++) check_eq({tag, "/m_data_r"}, m_data_r[DW*k +: DW], s_data_r);
    endtask

    task automatic run_cycle(string tag);
        #1 check_outputs(tag);
        @(posedge clk);
        if (resetn) model_edge();
        @(negedge clk);
    endtask

    task automatic drive(logic [N-1:0] en, logic stall);
        m_en    = en;
        s_stall = stall;
    endtask

    task automatic rand_payload();
        m_we     = N'($urandom);
        m_size   = (2*N)'($urandom);
        s_data_r = {$urandom, $urandom};
        for (int k = 0; k < N; k++) begin
            m_addr[AW*k +: AW]   = $urandom;
            m_data_w[DW*k +: DW] = {$urandom, $urandom};
        end
    endtask

    initial begin
        resetn = 1'b1;
        m_en = '0; m_we = '0; m_size = '0; m_addr = '0; m_data_w = '0;
        s_data_r = '0; s_stall = 1'b0;
        model_reset();
        exp_alt[0] = 4'b0010; exp_alt[1] = 4'b0001; exp_alt[2] = 4'b0010; exp_alt[3] = 4'b0001;
`ifdef SBUS_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) exp_alt[k] = 4'b0001;
`endif

        // Reset: outputs idle, stall mirrors enable, read data passes through.
        #2 resetn = 1'b0;
        rand_payload();
        m_en = 4'b0101;
        #1 check_outputs("reset");
        check_eq("reset/m_stall_eq_en", 64'(m_stall), 64'h5);
        @(negedge clk);
        resetn = 1'b1;
        drive('0, 1'b0);
        run_cycle("post_reset");

        // Single request on ch0.
        m_addr[AW-1:0] = 32'h1000;
        drive(4'b0001, 1'b0);
        run_cycle("single_req");
        #1 check_eq("single/s_en", 64'(s_en), 64'd1);
        check_eq("single/s_addr", 64'(s_addr), 64'h1000);
        check_eq("single/m_stall0", 64'(m_stall[0]), 64'd0);
        check_eq("single/m_data_r0", m_data_r[DW-1:0], s_data_r);
        run_cycle("single_busy");
        drive('0, 1'b0);
        #1 check_eq("single/idle_gnt", 64'(gnt), 64'd0);
        run_cycle("single_idle");

        // Contention: grants alternate (rr starts at 1 after ch0 completed).
        for (int i = 0; i < 8; i++) begin
            drive(4'b0011, 1'b0);
            #1 if (i % 2 == 1) check_eq("contend/gnt", 64'(gnt), 64'(exp_alt[i/2]));
            run_cycle("contend");
        end
        drive('0, 1'b0);
        run_cycle("contend_end");

        // Slave stall on ch1 for three busy cycles.
        drive(4'b0010, 1'b1);
        run_cycle("stall_req");
        for (int i = 0; i < 3; i++) begin
            drive(4'b0011, 1'b1);
            #1 check_eq("stall/m_stall", 64'(m_stall), 64'h3);
            check_eq("stall/gnt", 64'(gnt), 64'h2);
            run_cycle("stall_busy");
        end
        drive(4'b0011, 1'b0);
        #1 check_eq("stall/release", 64'(m_stall), 64'h1);
        run_cycle("stall_done");
        drive('0, 1'b0);
        run_cycle("stall_idle");

        // Withdrawal by ch0 mid-transfer; rr (now 2) must be untouched.
        drive(4'b0001, 1'b1);
        run_cycle("wd_req");
        #1 check_eq("wd/s_en_busy", 64'(s_en), 64'd1);
        run_cycle("wd_busy");
        drive('0, 1'b1);
        #1 check_eq("wd/s_en_drop", 64'(s_en), 64'd0);
        check_eq("wd/gnt_held", 64'(gnt), 64'h1);
        run_cycle("wd_drop");
        #1 check_eq("wd/idle", 64'(gnt), 64'd0);
        run_cycle("wd_idle");
        drive(4'b1111, 1'b0);
        run_cycle("wd_rr_req");
`ifdef SBUS_ARB_FIXED_PRIO_EN
        #1 check_eq("wd/rr_kept", 64'(gnt), 64'h1);
`else
        #1 check_eq("wd/rr_kept", 64'(gnt), 64'h4);
`endif
        run_cycle("wd_rr_busy");

        // Reset asserted mid-BUSY while slave stalls.
        drive(4'b1111, 1'b1);
        run_cycle("rst_req");
        #1 check_outputs("rst_busy");
        #2 resetn = 1'b0;
        #1 check_eq("rst/s_en", 64'(s_en), 64'd0);
        check_eq("rst/gnt", 64'(gnt), 64'd0);
        check_eq("rst/m_stall", 64'(m_stall), 64'hF);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        drive(4'b1111, 1'b0);
        run_cycle("rst_rearb");
        #1 check_eq("rst/from_rr0", 64'(gnt), 64'h1);
        run_cycle("rst_rearb_busy");

        // Highest channel, full 64-bit read data.
        drive(4'b1000, 1'b0);
        s_data_r = 64'hDEADBEEF_CAFEF00D;
        run_cycle("wide_req");
        #1 check_eq("wide/gnt", 64'(gnt), 64'h8);
        check_eq("wide/m_data_r3", m_data_r[3*DW +: DW], 64'hDEADBEEF_CAFEF00D);
        run_cycle("wide_busy");
        drive('0, 1'b0);
        run_cycle("wide_idle");

        // Randomized traffic; busy owners usually hold their request.
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            m_en = N'($urandom);
            if (md_busy && $urandom_range(0, 7) != 0) m_en[md_owner] = 1'b1;
            s_stall = ($urandom_range(0, 2) == 0);
            run_cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sbus_arbiter.md
SBUS_ARBITER -- requirements
Module: sbus_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of sbus master channels, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port m_en, input, N_CH bits: per-channel request enable.
REQ-007 SHALL have port m_we, input, N_CH bits: per-channel write enable.
REQ-008 SHALL have port m_size, input, 2*N_CH bits: per-channel access size, channel i at bits [2i+1:2i].
REQ-009 SHALL have port m_addr, input, ADDR_W*N_CH bits: per-channel address, packed like m_size.
REQ-010 SHALL have port m_data_w, input, DATA_W*N_CH bits: per-channel write data.
REQ-011 SHALL have port m_data_r, output, DATA_W*N_CH bits: per-channel read data.
REQ-012 SHALL have port m_stall, output, N_CH bits: per-channel stall.
REQ-013 SHALL have ports s_en, s_we (1 bit), s_size (2 bits), s_addr (ADDR_W bits) and s_data_w (DATA_W bits), all outputs: the single sbus slave request.
REQ-014 SHALL have port s_data_r, input, DATA_W bits: slave read data.
REQ-015 SHALL have port s_stall, input, 1 bit: slave stall.
REQ-016 SHALL have port gnt, output, N_CH bits: one-hot grant, for debug.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and BUSY, with a registered grant index g.
REQ-018 In IDLE with any m_en bit set, SHALL select a winner by round-robin starting at pointer rr, register g, and enter BUSY on the next edge.
REQ-019 In IDLE with m_en all zero, SHALL remain in IDLE.
REQ-020 In BUSY, SHALL drive s_en/s_we/s_size/s_addr/s_data_w from channel g combinationally, and gnt SHALL equal 1<<g.
REQ-021 Outside BUSY, SHALL drive s_en, s_we, s_size, s_addr, s_data_w and gnt to all zeros.
REQ-022 SHALL set m_stall[i] = m_en[i] for every channel except channel g in BUSY, where m_stall[g] = s_stall.
REQ-023 SHALL drive every m_data_r slice with s_data_r combinationally; the data is valid only for the channel whose m_en=1 and m_stall=0.
REQ-024 BUSY with s_stall=0 completes the transfer: next state IDLE, rr <= (g+1) mod N_CH.
REQ-025 BUSY with m_en[g]=0 (master withdrew, e.g. flush) SHALL return to IDLE without changing rr.
REQ-026 SHALL give a minimum latency of 2 cycles: request at cycle t, s_en at t+1, completion at t+1 if s_stall=0.
REQ-027 SHALL keep g stable for the whole of BUSY; requests from other channels arriving during BUSY SHALL NOT preempt.
REQ-028 Simultaneous completion and a new request from the same channel SHALL be handled in IDLE as a fresh request; there is no back-to-back bypass.

Reset
REQ-029 resetn=0 SHALL immediately force state IDLE, g=0, rr=0, gnt=0 and all s_* request outputs to 0, including when reset is asserted mid-BUSY.
REQ-030 While in reset, m_stall SHALL equal m_en, and m_data_r SHALL follow s_data_r.

Configuration
REQ-031 SHALL honour macro SBUS_ARB_FIXED_PRIO_EN.
REQ-032 With SBUS_ARB_FIXED_PRIO_EN defined, SHALL select the lowest-index requesting channel, and rr SHALL be absent or unused.
REQ-033 Without SBUS_ARB_FIXED_PRIO_EN, SHALL use round-robin per REQ-018/REQ-024.

Verification
REQ-034 Single request: N_CH=2, m_en=01, ch0 addr=0x1000, s_stall=0 -> s_en=1 and s_addr=0x1000 at t+1; m_stall[0]=0 and m_data_r[0]=s_data_r at t+1; IDLE at t+2.
REQ-035 Contention, round-robin: m_en=11 held, s_stall=0 always -> grants alternate 01,10,01,10 on successive BUSY cycles; with SBUS_ARB_FIXED_PRIO_EN defined, gnt=01 every time.
REQ-036 Slave stall: ch1 granted, s_stall=1 for 3 cycles then 0 -> m_stall[1]=1 for 3 BUSY cycles then 0; m_stall[0]=m_en[0] throughout; g unchanged.
REQ-037 Withdrawal: ch0 in BUSY drops m_en[0] -> s_en=0 same cycle, IDLE next cycle, rr unchanged.
REQ-038 Reset mid-op: resetn=0 during BUSY with s_stall=1 -> s_en=0 and gnt=0 immediately without a clock edge; after release, first request is arbitrated from rr=0.
REQ-039 Width/depth: N_CH=4, DATA_W=64, ch3 only requests, s_data_r=0xDEADBEEF_CAFEF00D -> m_data_r[3] equals that value and gnt=1000.
